// File: rtl/button_events_if.sv
// rtl/button_events_if.sv - bus port bundle for the button event block
// Single-cycle request/acknowledge register bus shared with the MCU.
interface button_events_if;
  logic [14:0] adr_i;
  logic [31:0] dat_i;
  logic [31:0] dat_o;
  logic        we_i;
  logic        stb_i;
  logic        ack_o;

  modport master (
    output adr_i, dat_i, we_i, stb_i,
    input  dat_o, ack_o
  );

  modport slave (
    input  adr_i, dat_i, we_i, stb_i,
    output dat_o, ack_o
  );
endinterface

// File: rtl/button_events.sv
// rtl/button_events.sv - button synchroniser, debouncer and edge-event registers
// Clean levels feed gp_o; sticky rise/fall flags are read and cleared over the bus.
module button_events #(
  parameter int WIDTH    = 8,
  parameter int TICK_DIV = 50000,
  parameter int STABLE   = 8
) (
  input  logic              clk,
  input  logic              rst,
  button_events_if.slave    bus,
  input  logic [WIDTH-1:0]  raw_i,
  output logic [WIDTH-1:0]  gp_o,
  output logic              irq_o
);
  localparam int PW = $clog2(TICK_DIV);
  localparam int CW = $clog2(STABLE + 1);

  logic [WIDTH-1:0] sync1, sync2;
  logic [PW-1:0]    pre_cnt;
  logic             tick;
  logic [CW-1:0]    cnt     [WIDTH];
  logic [CW-1:0]    cnt_nxt [WIDTH];
  logic [WIDTH-1:0] gp_nxt;
  logic [WIDTH-1:0] rise, fall, rise_en, fall_en;
  logic [WIDTH-1:0] rise_set, fall_set, rise_clr, fall_clr;
  logic             access, wr;
  logic [1:0]       adr;
  logic [31:0]      rd_data, ien_word;
  logic             unused_bus;

  assign unused_bus = &{1'b0, bus.adr_i[14:2], bus.dat_i};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1   <= '0;
      sync2   <= '0;
      pre_cnt <= '0;
    end else begin
      sync1   <= raw_i;
      sync2   <= sync1;
      pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
    end
  end

  assign tick = (pre_cnt == PW'(TICK_DIV - 1));

  // Any cycle where the synchronised input agrees with the level restarts the count.
  always_comb begin
    gp_nxt = gp_o;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_nxt[i] = cnt[i];
      if (sync2[i] == gp_o[i]) begin
        cnt_nxt[i] = '0;
      end else if (tick) begin
        if (cnt[i] == CW'(STABLE - 1)) begin
          gp_nxt[i]  = ~gp_o[i];
          cnt_nxt[i] = '0;
        end else begin
          cnt_nxt[i] = cnt[i] + 1'b1;
        end
      end
    end
  end

  assign rise_set = gp_nxt & ~gp_o;
  assign fall_set = ~gp_nxt & gp_o;

  assign access = bus.stb_i & ~bus.ack_o;
  assign wr     = access & bus.we_i;
  assign adr    = bus.adr_i[1:0];

  always_comb begin
    rise_clr = '0;
    fall_clr = '0;
    if (wr && adr == 2'd1) rise_clr = bus.dat_i[WIDTH-1:0];
    if (wr && adr == 2'd2) fall_clr = bus.dat_i[WIDTH-1:0];
  end

  always_comb begin
    ien_word              = '0;
    ien_word[WIDTH-1:0]   = rise_en;
    ien_word[16 +: WIDTH] = fall_en;
  end

  always_comb begin
    rd_data = '0;
    case (adr)
      2'd0:    rd_data = 32'(gp_o);
      2'd1:    rd_data = 32'(rise);
      2'd2:    rd_data = 32'(fall);
      default: rd_data = ien_word;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
      gp_o <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) cnt[i] <= cnt_nxt[i];
      gp_o <= gp_nxt;
    end
  end

  // Set beats clear so an edge landing on a clear write is never lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rise    <= '0;
      fall    <= '0;
      rise_en <= '0;
      fall_en <= '0;
      bus.ack_o <= 1'b0;
      bus.dat_o <= '0;
      irq_o   <= 1'b0;
    end else begin
      rise <= (rise & ~rise_clr) | rise_set;
      fall <= (fall & ~fall_clr) | fall_set;
      if (wr && adr == 2'd3) begin
        rise_en <= bus.dat_i[WIDTH-1:0];
        fall_en <= bus.dat_i[16 +: WIDTH];
      end
      bus.ack_o <= access;
      bus.dat_o <= access ? rd_data : '0;
      irq_o   <= (|(rise & rise_en)) | (|(fall & fall_en));
    end
  end
endmodule

// File: tb/tb_button_events.sv
// tb/tb_button_events.sv - self-checking bench for button_events
// Directed scenarios plus randomized traffic against a cycle-level behavioural model.
module tb_button_events;
  localparam int WIDTH    = 8;
  localparam int TICK_DIV = 4;
  localparam int STABLE   = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] raw;
  logic [WIDTH-1:0] gp;
  logic             irq;

  button_events_if bus ();

  button_events #(.WIDTH(WIDTH), .TICK_DIV(TICK_DIV), .STABLE(STABLE)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .raw_i (raw),
    .gp_o  (gp),
    .irq_o (irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference state: raw delayed twice, tick phase, ticks seen while mismatched.
  logic [WIDTH-1:0] m_s1, m_s2, m_gp, m_rise, m_fall, m_ren, m_fen;
  int               m_phase;
  int               m_run [WIDTH];
  logic             m_ack, m_irq;
  logic [31:0]      m_dat;

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_gp = '0; m_rise = '0; m_fall = '0;
    m_ren = '0; m_fen = '0; m_phase = 0; m_ack = 0; m_irq = 0; m_dat = '0;
    for (int i = 0; i < WIDTH; i++) m_run[i] = 0;
  endtask

  function automatic bit will_flip(input int b);
    return (m_s2[b] != m_gp[b]) && (m_phase == TICK_DIV - 1) && (m_run[b] + 1 == STABLE);
  endfunction

  task automatic step();
    logic [WIDTH-1:0] ngp, rs, fs, rc, fc, raw_now;
    logic [31:0]      rdv;
    int               nrun [WIDTH];
    bit               tk, acc, nirq;
    if (rst) begin
      @(posedge clk);
      #1;
      model_reset();
    end else begin
      raw_now = raw;
      tk  = (m_phase == TICK_DIV - 1);
      ngp = m_gp;
      for (int i = 0; i < WIDTH; i++) begin
        nrun[i] = m_run[i];
        if (m_s2[i] == m_gp[i]) nrun[i] = 0;
        else if (tk) begin
          nrun[i]++;
          if (nrun[i] == STABLE) begin
            ngp[i]  = ~m_gp[i];
            nrun[i] = 0;
          end
        end
      end
      rs  = ngp & ~m_gp;
      fs  = ~ngp & m_gp;
      acc = bus.stb_i && !m_ack;
      case (bus.adr_i[1:0])
        2'd0:    rdv = {24'b0, m_gp};
        2'd1:    rdv = {24'b0, m_rise};
        2'd2:    rdv = {24'b0, m_fall};
        default: rdv = {8'b0, m_fen, 8'b0, m_ren};
      endcase
      rc = (acc && bus.we_i && bus.adr_i[1:0] == 2'd1) ? bus.dat_i[7:0] : 8'h00;
      fc = (acc && bus.we_i && bus.adr_i[1:0] == 2'd2) ? bus.dat_i[7:0] : 8'h00;
      nirq = (|(m_rise & m_ren)) || (|(m_fall & m_fen));
      if (acc && bus.we_i && bus.adr_i[1:0] == 2'd3) begin
        m_ren = bus.dat_i[7:0];
        m_fen = bus.dat_i[23:16];
      end
      @(posedge clk);
      #1;
      m_rise  = (m_rise & ~rc) | rs;
      m_fall  = (m_fall & ~fc) | fs;
      m_gp    = ngp;
      for (int i = 0; i < WIDTH; i++) m_run[i] = nrun[i];
      m_irq   = nirq;
      m_ack   = acc;
      m_dat   = acc ? rdv : 32'h0;
      m_phase = (m_phase + 1) % TICK_DIV;
      m_s2    = m_s1;
      m_s1    = raw_now;
    end
    check("gp", 32'(gp), 32'(m_gp));
    check("irq", 32'(irq), 32'(m_irq));
    check("ack", 32'(bus.ack_o), 32'(m_ack));
    check("dat", bus.dat_o, m_dat);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    bus.adr_i = 15'(a); bus.dat_i = d; bus.we_i = 1'b1; bus.stb_i = 1'b1;
    step();
    bus.stb_i = 1'b0; bus.we_i = 1'b0;
    step();
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    bus.adr_i = 15'(a); bus.we_i = 1'b0; bus.stb_i = 1'b1;
    step();
    d = bus.dat_o;
    bus.stb_i = 1'b0;
    step();
  endtask

  task automatic wait_gp(input int b, input logic v, input int maxc, output int n);
    n = 0;
    while (gp[b] !== v && n < maxc) begin
      step();
      n++;
    end
  endtask

  logic [31:0] d;
  logic [5:0]  pat;
  int          n;
  bit          found;

  initial begin
    rst = 1'b1; raw = '0;
    bus.adr_i = '0; bus.dat_i = '0; bus.we_i = 1'b0; bus.stb_i = 1'b0;
    model_reset();
    repeat (2) step();

    // Reset in the middle of a debounce count
    rst = 1'b0; raw = 8'h01;
    repeat (8) step();
    rst = 1'b1;
    #1;
    model_reset();
    check("rst_gp", 32'(gp), 0);
    check("rst_irq", 32'(irq), 0);
    check("rst_ack", 32'(bus.ack_o), 0);
    check("rst_dat", bus.dat_o, 0);
    repeat (2) step();
    rst = 1'b0;
    wait_gp(0, 1'b1, 30, n);
    check("rst_lat", 32'(n >= 11 && n <= 14), 1);
    bus_read(2'd1, d);
    check("rst_rise", d, 32'h01);
    bus_write(2'd1, 32'h01);

    // Held edge and short glitch
    raw = 8'h05;
    wait_gp(2, 1'b1, 30, n);
    check("deb_lat", 32'(n >= 11 && n <= 14), 1);
    raw = 8'h0D;
    repeat (3) step();
    raw = 8'h05;
    repeat (20) step();
    check("glitch_gp", 32'(gp[3]), 0);
    bus_read(2'd1, d);
    check("glitch_rise", d, 32'h04);
    bus_read(2'd2, d);
    check("glitch_fall", d, 32'h00);
    bus_write(2'd1, 32'hFF);

    // Bounce then settle
    raw = 8'h04;
    repeat (20) step();
    bus_write(2'd2, 32'hFF);
    for (int k = 0; k < 10; k++) begin
      raw[0] = ~raw[0];
      repeat (2) step();
    end
    raw[0] = 1'b1;
    wait_gp(0, 1'b1, 20, n);
    check("bounce_settle", 32'(n >= 1 && n <= 14), 1);
    bus_read(2'd1, d);
    check("bounce_rise", d, 32'h01);
    bus_read(2'd2, d);
    check("bounce_fall", d, 32'h00);
    bus_write(2'd1, 32'hFF);

    // Register access and held strobe
    bus_write(2'd3, 32'h0000_00FF);
    bus_read(2'd3, d);
    check("ien_rd", d, 32'h0000_00FF);
    bus_write(2'd0, 32'hFFFF_FFFF);
    bus_read(2'd0, d);
    check("state_ro", d, 32'h0000_0005);
    bus.adr_i = 15'd0; bus.we_i = 1'b0; bus.stb_i = 1'b1;
    for (int k = 0; k < 6; k++) begin
      pat[5-k] = bus.ack_o;
      step();
    end
    bus.stb_i = 1'b0;
    step();
    check("ack_pat", 32'(pat), 32'h15);
    bus_write(2'd3, 32'h0);

    // Interrupt on rise and write-1-to-clear
    bus_write(2'd3, 32'h0000_0002);
    raw = 8'h07;
    wait_gp(1, 1'b1, 30, n);
    check("irq_pre", 32'(irq), 0);
    step();
    check("irq_set", 32'(irq), 1);
    bus_write(2'd1, 32'h02);
    check("irq_clr", 32'(irq), 0);

    // Edge coincident with a clear of the same flag
    raw = 8'h47;
    found = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      if (will_flip(6)) found = 1;
      else step();
    end
    check("setclr_found", 32'(found), 1);
    bus.adr_i = 15'd1; bus.dat_i = 32'h40; bus.we_i = 1'b1; bus.stb_i = 1'b1;
    step();
    bus.stb_i = 1'b0; bus.we_i = 1'b0;
    step();
    bus_read(2'd1, d);
    check("setclr_win", 32'(d[6]), 1);
    bus_write(2'd1, 32'hFF);
    bus_write(2'd3, 32'h0);

    // Falling path
    bus_write(2'd3, 32'h0020_0000);
    raw = 8'h67;
    wait_gp(5, 1'b1, 30, n);
    repeat (2) step();
    bus_write(2'd1, 32'hFF);
    raw = 8'h47;
    wait_gp(5, 1'b0, 30, n);
    check("fall_lat", 32'(n >= 11 && n <= 14), 1);
    step();
    check("fall_irq", 32'(irq), 1);
    bus_read(2'd2, d);
    check("fall_rd", d, 32'h20);
    bus_write(2'd2, 32'h20);
    bus_read(2'd2, d);
    check("fall_clr", d, 32'h00);
    check("fall_irq_clr", 32'(irq), 0);

    // Randomized traffic against the model
    bus_write(2'd3, $urandom);
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 11) == 0) raw[$urandom_range(0, WIDTH-1)] ^= 1'b1;
      bus.stb_i = ($urandom_range(0, 2) == 0);
      bus.we_i  = $urandom_range(0, 1);
      bus.adr_i = 15'($urandom);
      bus.dat_i = $urandom;
      if (c == 700) begin
        rst = 1'b1;
        #1;
        model_reset();
        check("rnd_rst_gp", 32'(gp), 0);
        step();
        step();
        rst = 1'b0;
      end
      step();
    end
    bus.stb_i = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
